// File: rtl/register_file_sb.sv
// Multi-ported register file with a per-register busy scoreboard.
// Two combinational read ports, one write-back port, one reserve port and a registered busy count.
module register_file_sb #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [ADDR_W:0]   busy_count_q;
    logic [ADDR_W:0]   busy_count_d;

    logic wr_en;
    logic rsv_en;
    logic rs_hit;
    logic rt_hit;
    logic rs_zero;
    logic rt_zero;

    // Accesses to a hard-wired zero register are dropped before they reach any state.
    always_comb begin
        wr_en  = write;
        rsv_en = reserve;
        if (ZERO_REG != 0) begin
            if (rd_addr == '0) begin
                wr_en = 1'b0;
            end
            if (reserve_addr == '0) begin
                rsv_en = 1'b0;
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[rd_addr] = data;
            busy_d[rd_addr] = 1'b0;
        end
        // Reserve is applied after the write so a same-address pair stays busy.
        if (rsv_en) begin
            busy_d[reserve_addr] = 1'b1;
        end
        busy_count_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        rs_hit  = (BYPASS != 0) && wr_en && (rd_addr == rs_addr);
        rt_hit  = (BYPASS != 0) && wr_en && (rd_addr == rt_addr);
        rs_zero = (ZERO_REG != 0) && (rs_addr == '0);
        rt_zero = (ZERO_REG != 0) && (rt_addr == '0);

        rs_data = rs_hit ? data : regs_q[rs_addr];
        rt_data = rt_hit ? data : regs_q[rt_addr];
        if (rs_zero) begin
            rs_data = '0;
        end
        if (rt_zero) begin
            rt_data = '0;
        end

        // A write landing this cycle resolves the hazard, so it no longer stalls.
        rs_busy = busy_q[rs_addr] && !rs_hit && !rs_zero;
        rt_busy = busy_q[rt_addr] && !rt_hit && !rt_zero;
        stall   = rs_busy || rt_busy;
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: default, no-bypass and zero-register instances
// share one stimulus stream and are checked against hand-computed values.
module tb_register_file_sb;

    logic        clock;
    logic        reset_n;
    logic        write;
    logic [2:0]  rd_addr;
    logic [15:0] data;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic        reserve;
    logic [2:0]  reserve_addr;

    logic [15:0] rs_data,    rt_data,    rs_data_nb, rt_data_nb, rs_data_z, rt_data_z;
    logic        rs_busy,    rt_busy,    stall;
    logic        rs_busy_nb, rt_busy_nb, stall_nb;
    logic        rs_busy_z,  rt_busy_z,  stall_z;
    logic [3:0]  busy_count, busy_count_nb, busy_count_z;

    int n_checks = 0;
    int n_errors = 0;

    register_file_sb dut (
        .clock(clock), .reset_n(reset_n), .write(write), .rd_addr(rd_addr), .data(data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .reserve(reserve), .reserve_addr(reserve_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .stall(stall), .busy_count(busy_count)
    );

    register_file_sb #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .write(write), .rd_addr(rd_addr), .data(data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data_nb), .rt_data(rt_data_nb),
        .reserve(reserve), .reserve_addr(reserve_addr), .rs_busy(rs_busy_nb), .rt_busy(rt_busy_nb),
        .stall(stall_nb), .busy_count(busy_count_nb)
    );

    register_file_sb #(.ZERO_REG(1)) dut_z (
        .clock(clock), .reset_n(reset_n), .write(write), .rd_addr(rd_addr), .data(data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data_z), .rt_data(rt_data_z),
        .reserve(reserve), .reserve_addr(reserve_addr), .rs_busy(rs_busy_z), .rt_busy(rt_busy_z),
        .stall(stall_z), .busy_count(busy_count_z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] rd, input logic [15:0] d,
                         input logic rsv, input logic [2:0] rsva,
                         input logic [2:0] rs, input logic [2:0] rt);
        write        = w;
        rd_addr      = rd;
        data         = d;
        reserve      = rsv;
        reserve_addr = rsva;
        rs_addr      = rs;
        rt_addr      = rt;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 3'd1, 16'h5555, 1'b1, 3'd1, 3'd0, 3'd0);
        tick();

        // Reset held low across an edge: the write/reserve must not land.
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1, 3'd1);
        check("rst_rs_data", rs_data, 0);
        check("rst_rt_data", rt_data, 0);
        check("rst_rs_busy", rs_busy, 0);
        check("rst_stall", stall, 0);
        check("rst_count", busy_count, 0);
        reset_n = 1'b1;
        #1;
        check("post_rst_rs_data", rs_data, 0);
        check("post_rst_busy", rt_busy, 0);

        // r0 = 0x0001, r7 = 0x00AB
        tick();
        drive(1'b1, 3'd0, 16'h0001, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        drive(1'b1, 3'd7, 16'h00AB, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd7);
        check("rd_r0", rs_data, 16'h0001);
        check("rd_r7", rt_data, 16'h00AB);
        check("nb_rd_r0", rs_data_nb, 16'h0001);
        check("z_rd_r0", rs_data_z, 16'h0000);
        check("z_rd_r7", rt_data_z, 16'h00AB);

        // Same-cycle forwarding vs. old value
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd3, 3'd7);
        check("byp_rs", rs_data, 16'h1234);
        check("nobyp_rs", rs_data_nb, 16'h0000);
        check("byp_rt_other", rt_data, 16'h00AB);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd7, 3'd3);
        check("nb_r3_after", rt_data_nb, 16'h1234);

        // Reserve r2 and resolve it with a write
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2, 3'd7);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd7);
        check("rsv2_rs_busy", rs_busy, 1);
        check("rsv2_rt_busy", rt_busy, 0);
        check("rsv2_stall", stall, 1);
        check("rsv2_count", busy_count, 1);
        drive(1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd2, 3'd7);
        check("wr2_byp_busy", rs_busy, 0);
        check("wr2_byp_stall", stall, 0);
        check("wr2_nobyp_busy", rs_busy_nb, 1);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd7);
        check("wr2_count", busy_count, 0);
        check("wr2_stall", stall, 0);
        check("wr2_data", rs_data, 16'h2222);

        // Reserve and write r5 together: set wins
        drive(1'b1, 3'd5, 16'h0505, 1'b1, 3'd5, 3'd5, 3'd7);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd7);
        check("rw5_data", rs_data, 16'h0505);
        check("rw5_busy", rs_busy, 1);
        check("rw5_count", busy_count, 1);

        // Re-reserve busy r5: count unchanged
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd5, 3'd7);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd7);
        check("rersv5_count", busy_count, 1);
        check("rersv5_busy", rs_busy, 1);

        // Write non-busy r4: data updates, count unchanged
        drive(1'b1, 3'd4, 16'h0404, 1'b0, 3'd0, 3'd4, 3'd5);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd4, 3'd5);
        check("wr4_data", rs_data, 16'h0404);
        check("wr4_count", busy_count, 1);

        // Reserve r6 while writing busy r5: net zero
        drive(1'b1, 3'd5, 16'h5A5A, 1'b1, 3'd6, 3'd5, 3'd6);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd6);
        check("net0_count", busy_count, 1);
        check("net0_rs_busy", rs_busy, 0);
        check("net0_rt_busy", rt_busy, 1);
        check("net0_data", rs_data, 16'h5A5A);

        // Reserve every register
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'd0, 3'd0);
            tick();
        end
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd7, 3'd0);
        check("all_count", busy_count, 8);
        check("all_count_z", busy_count_z, 7);
        check("all_stall", stall, 1);
        check("z_r0_busy", rt_busy_z, 0);
        check("all_r7_data", rs_data, 16'h00AB);

        // Asynchronous reset mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        check("async_count", busy_count, 0);
        check("async_count_z", busy_count_z, 0);
        check("async_rs_data", rs_data, 0);
        check("async_rs_busy", rs_busy, 0);
        check("async_stall", stall, 0);
        tick();
        reset_n = 1'b1;

        // Zero register ignores write and reserve, even when forwarded
        drive(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
        check("z_byp_rs_data", rs_data_z, 0);
        check("z_byp_rs_busy", rs_busy_z, 0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        check("z_rs_data", rs_data_z, 0);
        check("z_rs_busy", rs_busy_z, 0);
        check("z_count", busy_count_z, 0);
        check("nz_r0_data", rs_data, 16'hFFFF);
        check("nz_r0_count", busy_count, 1);
        check("nz_r0_busy", rs_busy, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning address width; register count = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes and reserves.
REQ-004 The block SHALL have parameter BYPASS, default 1; when 1, same-cycle write data forwards to the read ports.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The block SHALL have port clock, input, 1 bit, meaning rising-edge system clock.
REQ-007 The block SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-008 The block SHALL have port write, input, 1 bit, meaning write-back enable.
REQ-009 The block SHALL have port rd_addr, input, ADDR_W bits, meaning write-back destination.
REQ-010 The block SHALL have port data, input, DATA_W bits, meaning write-back value.
REQ-011 The block SHALL have port rs_addr, input, ADDR_W bits, meaning read port A address.
REQ-012 The block SHALL have port rt_addr, input, ADDR_W bits, meaning read port B address.
REQ-013 The block SHALL have port rs_data, output, DATA_W bits, meaning read port A data.
REQ-014 The block SHALL have port rt_data, output, DATA_W bits, meaning read port B data.
REQ-015 The block SHALL have port reserve, input, 1 bit, meaning mark a register as pending a write.
REQ-016 The block SHALL have port reserve_addr, input, ADDR_W bits, meaning register to reserve.
REQ-017 The block SHALL have port rs_busy, output, 1 bit, meaning rs_addr has a pending write.
REQ-018 The block SHALL have port rt_busy, output, 1 bit, meaning rt_addr has a pending write.
REQ-019 The block SHALL have port stall, output, 1 bit, meaning rs_busy OR rt_busy.
REQ-020 The block SHALL have port busy_count, output, ADDR_W+1 bits, meaning number of busy registers.

Function
REQ-021 The block SHALL update storage on the rising clock edge: if write, reg[rd_addr] <= data.
REQ-022 The block SHALL read combinationally: rs_data = reg[rs_addr] and rt_data = reg[rt_addr].
REQ-023 With BYPASS=1, when write is high and rd_addr equals a read address, that port SHALL output data in the same cycle; with BYPASS=0 it SHALL output the old value.
REQ-024 With ZERO_REG=1, address 0 SHALL read as 0, never be busy, and writes and reserves to it SHALL be dropped.
REQ-025 The scoreboard SHALL hold one busy bit per register; on a clock edge, reserve sets busy[reserve_addr] and write clears busy[rd_addr].
REQ-026 When reserve and write target the same address in the same cycle, the set SHALL win and the bit stays busy.
REQ-027 Reserving an already-busy register SHALL leave it busy and SHALL NOT change busy_count.
REQ-028 Writing a non-busy register SHALL update data and SHALL NOT change busy_count.
REQ-029 rs_busy SHALL be busy[rs_addr]; with BYPASS=1 it SHALL be forced low while write hits rs_addr. rt_busy SHALL follow the same rule with rt_addr.
REQ-030 busy_count SHALL be registered and equal the population count of busy bits after each edge, with net +1, -1 or 0 on simultaneous reserve and write.
REQ-031 busy_count SHALL reach 2**ADDR_W when all registers are busy (2**ADDR_W-1 with ZERO_REG=1) without wrapping.

Reset
REQ-032 While reset_n is low, all registers, busy bits and busy_count SHALL clear to 0 immediately, regardless of clock.
REQ-033 After reset, rs_data, rt_data, rs_busy, rt_busy and stall SHALL be 0.
REQ-034 A write or reserve in the cycle reset_n rises SHALL NOT take effect until the next rising edge with reset_n high.

Verification
REQ-035 Write 0x0001 to r0 and 0x00AB to r7, then read rs=0 and rt=7 -> rs_data=0x0001, rt_data=0x00AB (ZERO_REG=0).
REQ-036 With BYPASS=1, write=1, rd_addr=3, data=0x1234, rs_addr=3 in the same cycle -> rs_data=0x1234 before the edge; with BYPASS=0 -> old value.
REQ-037 Reserve r2, then set rs_addr=2 -> rs_busy=1, stall=1, busy_count=1; write r2 -> busy_count=0, stall=0.
REQ-038 Reserve and write r5 in the same cycle -> r5 holds the new data, busy[5]=1, busy_count unchanged by the write.
REQ-039 Reserve all 8 registers -> busy_count=8; assert reset_n low mid-clock -> all outputs 0 immediately.
REQ-040 With ZERO_REG=1, write 0xFFFF to r0 and reserve r0 -> rs_data=0, rs_busy=0, busy_count=0.
